chunked_adder: RTL and testbench

CHUNKED_ADDER -- requirements
Module: chunked_adder

---
 rtl/chunked_adder.sv | 96 +++++++++
 tb/tb_chunked_adder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle adder summing CHUNK bits per clock, LSB chunk first.
// Define CHUNKED_ADDER_SUB_EN to add a 'sub' port selecting a - b.
module chunked_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CHUNKED_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             busy
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_b_in;
    logic             w_c_in;
    logic [31:0]      w_lo;
    logic [CHUNK:0]   w_sum;
    logic             w_last;

    // Subtraction is folded into the operands at accept time: a + ~b + 1.
`ifdef CHUNKED_ADDER_SUB_EN
    assign w_b_in = sub ? ~b : b;
    assign w_c_in = sub | cin;
`else
    assign w_b_in = b;
    assign w_c_in = cin;
`endif

    assign w_lo   = CHUNK * 32'(r_cnt);
    assign w_sum  = {1'b0, r_a[w_lo +: CHUNK]} + {1'b0, r_b[w_lo +: CHUNK]} + {{CHUNK{1'b0}}, r_carry};
    assign w_last = r_cnt == CW'(NCHUNK - 1);

    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == DONE;
    assign busy      = r_state != IDLE;
    assign s         = r_s;
    assign cout      = r_cout;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = in_valid ? RUN : IDLE;
            RUN:     w_next = w_last ? DONE : RUN;
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && in_valid) begin
                r_a     <= a;
                r_b     <= w_b_in;
                r_carry <= w_c_in;
                r_cnt   <= '0;
                r_s     <= '0;
            end else if (r_state == RUN) begin
                r_s[w_lo +: CHUNK] <= w_sum[CHUNK-1:0];
                r_carry            <= w_sum[CHUNK];
                r_cnt              <= r_cnt + CW'(1);
                if (w_last) r_cout <= w_sum[CHUNK];
            end
        end
    end
endmodule

// File: tb/tb_chunked_adder.sv
// tb_chunked_adder: randomized and directed checks of chunked_adder (WIDTH=8, CHUNK=2)
// against an arithmetic reference model.
module tb_chunked_adder;
    localparam int WIDTH = 8;
    localparam int CHUNK = 2;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             busy;

    int n_checks = 0;
    int n_fail = 0;

    chunked_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef CHUNKED_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] ma, mb, input logic mc, ms);
        return ms ? {1'b0, ma} + {1'b0, ~mb} + (WIDTH+1)'(1)
                  : {1'b0, ma} + {1'b0, mb} + {{WIDTH{1'b0}}, mc};
    endfunction

    // Offers one operation from IDLE and waits (bounded) for out_valid.
    task automatic run_op(input logic [WIDTH-1:0] ta, tb_v, input logic tc,
                          output int lat, output logic [WIDTH-1:0] rs, output logic rc);
        a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        rs = s; rc = cout;
    endtask

    task automatic release_out;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        int lat; logic [WIDTH-1:0] rs; logic rc;
        rst_n = 1'b0; in_valid = 1'b1; a = 8'hAA; b = 8'h55; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (s !== 8'h00) begin n_fail++; $display("FAIL reset_s got %h want 00", s); end
        n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got %b want 0", cout); end
        out_ready = 1'b0; rst_n = 1'b1;
        run_op(8'hFF, 8'h01, 1'b0, lat, rs, rc);
        n_checks++; if (lat !== NCHUNK) begin n_fail++; $display("FAIL first_accept_latency got %0d want %0d", lat, NCHUNK); end
        n_checks++; if ({rc, rs} !== 9'h100) begin n_fail++; $display("FAIL ff_plus_01 got %h want 100", {rc, rs}); end
        release_out();
    endtask

    task automatic test_hold;
        int lat; logic [WIDTH-1:0] rs; logic rc;
        run_op(8'h5A, 8'h25, 1'b1, lat, rs, rc);
        n_checks++; if ({rc, rs} !== 9'h080) begin n_fail++; $display("FAIL hold_result got %h want 080", {rc, rs}); end
        n_checks++; if (lat !== NCHUNK) begin n_fail++; $display("FAIL hold_latency got %0d want %0d", lat, NCHUNK); end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 8'h11; b = 8'h22;
            @(posedge clk); #1;
            n_checks++; if ({out_valid, cout, s} !== 10'b1_0_1000_0000) begin
                n_fail++; $display("FAIL hold_stable got v=%b c=%b s=%h want v=1 c=0 s=80", out_valid, cout, s);
            end
        end
        in_valid = 1'b0;
        release_out();
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL release_idle got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        n_checks++; if (s !== 8'h80) begin n_fail++; $display("FAIL idle_keeps_s got %h want 80", s); end
    endtask

    task automatic test_input_change;
        int lat = -1;
        a = 8'h10; b = 8'h20; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b1 || s !== 8'h00) begin
            n_fail++; $display("FAIL accept_clears got busy=%b s=%h want 1 00", busy, s);
        end
        for (int n = 0; n <= 20; n++) begin
            if (n > 0) begin
                @(posedge clk); #1;
                if (out_valid) begin lat = n; break; end
            end
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            in_valid = 1'($urandom); out_ready = 1'($urandom);
        end
        out_ready = 1'b0; in_valid = 1'b0;
        n_checks++; if (lat !== NCHUNK) begin n_fail++; $display("FAIL change_latency got %0d want %0d", lat, NCHUNK); end
        n_checks++; if ({cout, s} !== 9'h030) begin n_fail++; $display("FAIL change_result got %h want 030", {cout, s}); end
        release_out();
    endtask

    task automatic test_reset_abort;
        int lat; logic [WIDTH-1:0] rs; logic rc;
        a = 8'hF3; b = 8'h9C; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({out_valid, in_ready, busy} !== 3'b010 || s !== 8'h00) begin
            n_fail++; $display("FAIL abort got v=%b rdy=%b busy=%b s=%h want 0 1 0 00", out_valid, in_ready, busy, s);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(8'h01, 8'h01, 1'b0, lat, rs, rc);
        n_checks++; if ({rc, rs} !== 9'h002 || lat !== NCHUNK) begin
            n_fail++; $display("FAIL after_abort got %h lat %0d want 002 lat %0d", {rc, rs}, lat, NCHUNK);
        end
        release_out();
    endtask

    task automatic test_random;
        int lat; logic [WIDTH-1:0] rs, ta, tbv; logic rc, tc; logic [WIDTH:0] exp;
        for (int i = 0; i < 25; i++) begin
            ta = 8'($urandom); tbv = 8'($urandom); tc = 1'($urandom);
            if (i == 0) begin ta = 8'hFF; tbv = 8'hFF; tc = 1'b1; end
            if (i == 1) begin ta = 8'h00; tbv = 8'h00; tc = 1'b0; end
            exp = model(ta, tbv, tc, 1'b0);
            run_op(ta, tbv, tc, lat, rs, rc);
            n_checks++; if ({rc, rs} !== exp || lat !== NCHUNK) begin
                n_fail++; $display("FAIL random_add %h+%h+%b got %h lat %0d want %h lat %0d", ta, tbv, tc, {rc, rs}, lat, exp, NCHUNK);
            end
            release_out();
        end
    endtask

    task automatic test_back_to_back;
        int lat = -1;
        a = 8'h33; b = 8'h44; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = n; break; end
        end
        a = 8'h80; b = 8'h80; cin = 1'b0;
        n_checks++; if (lat !== NCHUNK + 1 || {cout, s} !== 9'h078) begin
            n_fail++; $display("FAIL b2b_first got %h lat %0d want 078 lat %0d", {cout, s}, lat, NCHUNK + 1);
        end
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle got in_ready=%b want 1", in_ready); end
        out_ready = 1'b0;
        lat = -1;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = n; break; end
        end
        in_valid = 1'b0;
        n_checks++; if (lat !== NCHUNK + 1 || {cout, s} !== 9'h100) begin
            n_fail++; $display("FAIL b2b_second got %h lat %0d want 100 lat %0d", {cout, s}, lat, NCHUNK + 1);
        end
        release_out();
    endtask

`ifdef CHUNKED_ADDER_SUB_EN
    task automatic test_sub;
        int lat; logic [WIDTH-1:0] rs, ta, tbv; logic rc; logic [WIDTH:0] exp;
        for (int i = 0; i < 12; i++) begin
            ta = 8'($urandom); tbv = 8'($urandom);
            if (i == 0) begin ta = 8'h05; tbv = 8'h07; end
            if (i == 1) begin ta = 8'h07; tbv = 8'h05; end
            exp = model(ta, tbv, 1'b0, 1'b1);
            sub = 1'b1;
            run_op(ta, tbv, 1'($urandom), lat, rs, rc);
            sub = 1'b0;
            n_checks++; if ({rc, rs} !== exp) begin
                n_fail++; $display("FAIL sub %h-%h got %h want %h", ta, tbv, {rc, rs}, exp);
            end
            release_out();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_hold();
        test_input_change();
        test_reset_abort();
        test_random();
        test_back_to_back();
`ifdef CHUNKED_ADDER_SUB_EN
        test_sub();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
